// File: rtl/bus_arbiter_2.sv
// -----------------------------------------------------------------------------
// bus_arbiter_2
//
// Two-master round-robin arbiter in front of a single host bus port. Master 0
// is normally the CPU core and master 1 a DMA/blitter. One master owns the bus
// for exactly one transaction: its request is forwarded downstream, the device
// response is routed back to it, and a watchdog aborts transactions the device
// never completes.
//
// Parameters
//   TIMEOUT_CYCLES  BUSY cycles without dev_ready before abort (0 = no watchdog)
//   ERR_DATA        read data returned to the owner on an aborted transaction
//
// Ports
//   clk, rst                  bus clock, asynchronous active-high reset
//   m0_addr/wdata/wmask       master 0 request fields, held until m0_ready
//   m0_wen, m0_ren            master 0 write / read request
//   m0_rdata, m0_ready        master 0 response (rdata is 0 unless ready)
//   m1_*                      same set for master 1
//   dev_addr/wdata/wmask      forwarded request fields (0 while idle)
//   dev_wen, dev_ren          forwarded write / read strobes
//   dev_rdata, dev_ready      device response
//   grant                     one-hot owner {m1,m0}, 00 while idle
//   timeout_err               sticky watchdog-abort flag, cleared by rst only
// -----------------------------------------------------------------------------
module bus_arbiter_2 #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_wen,
  input  logic        m0_ren,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,

  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_wen,
  input  logic        m1_ren,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,

  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic [3:0]  dev_wmask,
  output logic        dev_wen,
  output logic        dev_ren,
  input  logic [31:0] dev_rdata,
  input  logic        dev_ready,

  output logic [1:0]  grant,
  output logic        timeout_err
);

  // Watchdog width: wide enough to hold TIMEOUT_CYCLES, clamped to 8..32 bits.
  localparam int unsigned WD_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WD_W   = (WD_RAW < 8) ? 8 : ((WD_RAW > 32) ? 32 : WD_RAW);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t          state;
  logic            owner;       // 0 = m0, 1 = m1; valid while BUSY
  logic            last_owner;  // owner of the most recently finished transaction
  logic [1:0]      grant_q;
  logic [WD_W-1:0] wdog;
  logic            timeout_q;

  logic        req0;
  logic        req1;
  logic        pick;
  logic        busy;
  logic        wd_expired;
  logic        abort;
  logic        done;
  logic [31:0] rsp_data;

  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wmask;
  logic        sel_wen;
  logic        sel_ren;

  // ---------------------------------------------------------------------------
  // Arbitration decision and completion conditions
  // ---------------------------------------------------------------------------
  always_comb begin
    req0 = m0_wen | m0_ren;
    req1 = m1_wen | m1_ren;
    // Tie goes to whoever did not finish last; otherwise the sole requester.
    pick = (req0 && req1) ? ~last_owner : req1;

    busy       = (state == ST_BUSY);
    wd_expired = WD_EN && busy && (wdog >= WD_LIMIT);
    // A response arriving in the expiry cycle still counts as a real response.
    abort      = wd_expired && !dev_ready;
    done       = busy && (dev_ready || wd_expired);
    rsp_data   = abort ? ERR_DATA : dev_rdata;
  end

  // ---------------------------------------------------------------------------
  // Owner request mux
  // ---------------------------------------------------------------------------
  always_comb begin
    if (owner) begin
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
      sel_wmask = m1_wmask;
      sel_wen   = m1_wen;
      sel_ren   = m1_ren;
    end else begin
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
      sel_wmask = m0_wmask;
      sel_wen   = m0_wen;
      sel_ren   = m0_ren;
    end
  end

  // ---------------------------------------------------------------------------
  // Downstream request: only the owner's fields, and only while BUSY. Strobes
  // drop in the abort cycle so the device does not see a fresh access.
  // ---------------------------------------------------------------------------
  always_comb begin
    dev_addr  = busy ? sel_addr  : 32'h0;
    dev_wdata = busy ? sel_wdata : 32'h0;
    dev_wmask = busy ? sel_wmask : 4'h0;
    dev_wen   = busy && !abort && sel_wen;
    dev_ren   = busy && !abort && sel_ren;
  end

  // ---------------------------------------------------------------------------
  // Upstream response: same-cycle pass-through to the owner only
  // ---------------------------------------------------------------------------
  always_comb begin
    m0_ready = done && !owner;
    m1_ready = done &&  owner;
    m0_rdata = m0_ready ? rsp_data : 32'h0;
    m1_rdata = m1_ready ? rsp_data : 32'h0;
  end

  assign grant       = grant_q;
  assign timeout_err = timeout_q;

  // ---------------------------------------------------------------------------
  // Control FSM with owner / fairness / watchdog registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;  // m0 wins the first tie after reset
      grant_q    <= 2'b00;
      wdog       <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            owner   <= pick;
            grant_q <= pick ? 2'b10 : 2'b01;
            wdog    <= '0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (done) begin
            last_owner <= owner;
            grant_q    <= 2'b00;
            state      <= ST_IDLE;
            if (abort) begin
              timeout_q <= 1'b1;
            end
          end else if (wdog != '1) begin
            wdog <= wdog + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2.sv
module tb_bus_arbiter_2;

  localparam int          TO  = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [3:0]  m0_wmask = '0;
  logic        m0_wen = 1'b0, m0_ren = 1'b0;
  logic [31:0] m0_rdata;
  logic        m0_ready;

  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_wmask = '0;
  logic        m1_wen = 1'b0, m1_ren = 1'b0;
  logic [31:0] m1_rdata;
  logic        m1_ready;

  logic [31:0] dev_addr, dev_wdata;
  logic [3:0]  dev_wmask;
  logic        dev_wen, dev_ren;
  logic [31:0] dev_rdata = '0;
  logic        dev_ready = 1'b0;

  logic [1:0]  grant;
  logic        timeout_err;

  bus_arbiter_2 #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_wen(m0_wen), .m0_ren(m0_ren), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_wen(m1_wen), .m1_ren(m1_ren), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_wmask(dev_wmask),
    .dev_wen(dev_wen), .dev_ren(dev_ren), .dev_rdata(dev_rdata), .dev_ready(dev_ready),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic [31:0] rdata;
    logic        to;
    int          busy;
    logic        lat_chk;
    int          start;
  } job_t;

  job_t q0[$], q1[$], exp0[$], exp1[$];
  int   order_log[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   dev_lat  = 1;
  int   dcnt     = 0;
  int   bcnt     = 0;
  logic act0 = 1'b0, act1 = 1'b0, done0 = 1'b0, done1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dev_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'h1234_5678 : {a[15:0], ~a[15:0]};
  endfunction

  function automatic job_t mk(input logic [31:0] a, input logic w, input logic [31:0] wd,
                              input logic [3:0] wm, input int lat, input logic to,
                              input logic lc);
    job_t j;
    j.addr    = a;
    j.wen     = w;
    j.wdata   = wd;
    j.wmask   = wm;
    j.to      = to;
    j.rdata   = to ? ERR : dev_fn(a);
    j.busy    = to ? TO + 1 : lat + 1;
    j.lat_chk = lc;
    j.start   = 0;
    return j;
  endfunction

  task automatic load(input int m, input job_t j);
    if (m == 0) begin
      m0_addr = j.addr; m0_wdata = j.wdata; m0_wmask = j.wmask;
      m0_wen = j.wen; m0_ren = !j.wen;
    end else begin
      m1_addr = j.addr; m1_wdata = j.wdata; m1_wmask = j.wmask;
      m1_wen = j.wen; m1_ren = !j.wen;
    end
  endtask

  task automatic on_ready(input int m);
    job_t        j;
    logic [31:0] rd;
    logic [31:0] g;
    if (m == 0) begin
      if (exp0.size() == 0) begin check("m0_unexpected_ready", 32'd1, 32'd0); return; end
      j = exp0.pop_front(); rd = m0_rdata; g = 32'd1; done0 = 1'b1;
    end else begin
      if (exp1.size() == 0) begin check("m1_unexpected_ready", 32'd1, 32'd0); return; end
      j = exp1.pop_front(); rd = m1_rdata; g = 32'd2; done1 = 1'b1;
    end
    order_log.push_back(m);
    check("grant_at_ready", 32'(grant), g);
    check("rdata", rd, j.rdata);
    check("busy_cycles", 32'(bcnt), 32'(j.busy));
    if (j.to) begin
      check("abort_dev_en", 32'({dev_wen, dev_ren}), 32'd0);
    end else begin
      check("dev_addr", dev_addr, j.addr);
      check("dev_wen", 32'(dev_wen), 32'(j.wen));
      check("dev_ren", 32'(dev_ren), 32'(!j.wen));
      if (j.wen) begin
        check("dev_wdata", dev_wdata, j.wdata);
        check("dev_wmask", 32'(dev_wmask), 32'(j.wmask));
      end
    end
  endtask

  // Bus functional models: device and both masters act 1 after the rising
  // edge, the response monitor samples on the falling edge.
  initial begin : bfm
    job_t j;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        m0_wen = 1'b0; m0_ren = 1'b0; m1_wen = 1'b0; m1_ren = 1'b0;
        act0 = 1'b0; act1 = 1'b0; done0 = 1'b0; done1 = 1'b0;
        exp0.delete(); exp1.delete();
        dev_ready = 1'b0; dev_rdata = '0; dcnt = 0;
      end else begin
        if (grant != 2'b00) begin
          if (dcnt == dev_lat) begin
            dev_ready = 1'b1; dev_rdata = dev_fn(dev_addr);
          end else begin
            dev_ready = 1'b0; dev_rdata = 32'hBAD0_0000 | 32'(dcnt);
          end
          dcnt++;
        end else begin
          dev_ready = 1'b0; dev_rdata = '0; dcnt = 0;
        end
        if (done0) begin act0 = 1'b0; m0_wen = 1'b0; m0_ren = 1'b0; done0 = 1'b0; end
        if (done1) begin act1 = 1'b0; m1_wen = 1'b0; m1_ren = 1'b0; done1 = 1'b0; end
        if (!act0 && q0.size() != 0) begin
          j = q0.pop_front(); j.start = cyc; exp0.push_back(j); load(0, j); act0 = 1'b1;
        end
        if (!act1 && q1.size() != 0) begin
          j = q1.pop_front(); j.start = cyc; exp1.push_back(j); load(1, j); act1 = 1'b1;
        end
      end
      @(negedge clk);
      if (rst) begin
        bcnt = 0;
      end else begin
        if (m0_ready && m1_ready) check("both_ready", 32'd1, 32'd0);
        if (!m0_ready) check("m0_rdata_idle", m0_rdata, 32'd0);
        if (!m1_ready) check("m1_rdata_idle", m1_rdata, 32'd0);
        if (grant == 2'b00) begin
          bcnt = 0;
          check("idle_dev_en", 32'({dev_wen, dev_ren}), 32'd0);
          if (m0_ready || m1_ready) check("idle_ready", 32'd1, 32'd0);
        end else begin
          bcnt++;
          if (bcnt == 1 && grant == 2'b01 && exp0.size() != 0 && exp0[0].lat_chk)
            check("m0_grant_latency", 32'(cyc), 32'(exp0[0].start + 1));
          if (m0_ready) on_ready(0);
          if (m1_ready) on_ready(1);
        end
      end
    end
  end

  task automatic wait_idle(input string tag);
    int   n;
    logic pending;
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
      pending = (q0.size() != 0) || (q1.size() != 0) || act0 || act1;
    end while (pending && n < 300);
    check({tag, "_drained"}, 32'(pending), 32'd0);
    check({tag, "_exp_left"}, 32'(exp0.size() + exp1.size()), 32'd0);
  endtask

  initial begin : main
    int base;
    int first;
    int n;

    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_dev_en", 32'({dev_wen, dev_ren}), 32'd0);
    check("rst_dev_addr", dev_addr, 32'd0);
    check("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single m0 read, device answers on the second BUSY cycle
    dev_lat = 1;
    base = order_log.size();
    q0.push_back(mk(32'h0000_0010, 1'b0, '0, '0, 1, 1'b0, 1'b1));
    wait_idle("t1");
    check("t1_count", 32'(order_log.size() - base), 32'd1);
    check("t1_owner", 32'(order_log[base]), 32'd0);
    check("t1_grant_after", 32'(grant), 32'd0);

    // both masters continuously requesting: strict alternation
    dev_lat = 2;
    base  = order_log.size();
    first = 1 - order_log[base - 1];
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(32'h0000_0100 + 32'(i * 4), 1'b0, '0, '0, 2, 1'b0, 1'b0));
      q1.push_back(mk(32'h0000_0200 + 32'(i * 4), 1'b0, '0, '0, 2, 1'b0, 1'b0));
    end
    wait_idle("t2");
    check("t2_count", 32'(order_log.size() - base), 32'd8);
    for (int i = 0; i < 8; i++)
      check("t2_order", 32'(order_log[base + i]), 32'(first ^ (i & 1)));

    // m1 masked write while m0 waits
    dev_lat = 0;
    base = order_log.size();
    q1.push_back(mk(32'h0002_0040, 1'b1, 32'hCAFE_F00D, 4'b0011, 0, 1'b0, 1'b0));
    @(negedge clk);
    q0.push_back(mk(32'h0000_0300, 1'b0, '0, '0, 0, 1'b0, 1'b0));
    wait_idle("t3");
    check("t3_count", 32'(order_log.size() - base), 32'd2);
    check("t3_first", 32'(order_log[base]), 32'd1);
    check("t3_second", 32'(order_log[base + 1]), 32'd0);

    // response in the very cycle the watchdog expires: real data wins
    dev_lat = TO;
    q0.push_back(mk(32'h0000_0400, 1'b0, '0, '0, TO, 1'b0, 1'b0));
    wait_idle("t5");
    check("t5_timeout_err", 32'(timeout_err), 32'd0);

    // hung device: abort with ERR_DATA, then other master proceeds
    dev_lat = -1;
    base = order_log.size();
    q1.push_back(mk(32'h0000_0500, 1'b0, '0, '0, 0, 1'b1, 1'b0));
    wait_idle("t4a");
    check("t4_timeout_err_set", 32'(timeout_err), 32'd1);
    dev_lat = 1;
    q0.push_back(mk(32'h0000_0600, 1'b0, '0, '0, 1, 1'b0, 1'b0));
    wait_idle("t4b");
    check("t4_timeout_err_sticky", 32'(timeout_err), 32'd1);
    check("t4_order_a", 32'(order_log[base]), 32'd1);
    check("t4_order_b", 32'(order_log[base + 1]), 32'd0);

    // reset in the middle of a transaction
    dev_lat = -1;
    q0.push_back(mk(32'h0000_0700, 1'b0, '0, '0, 0, 1'b1, 1'b0));
    n = 0;
    while (grant != 2'b01 && n < 20) begin @(negedge clk); n++; end
    check("t6_busy_before_rst", 32'(grant), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_dev_en", 32'({dev_wen, dev_ren}), 32'd0);
    check("t6_rst_dev_addr", dev_addr, 32'd0);
    check("t6_rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
    check("t6_rst_m0_rdata", m0_rdata, 32'd0);
    check("t6_rst_timeout_err", 32'(timeout_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dev_lat = 1;
    base = order_log.size();
    q0.push_back(mk(32'h0000_0800, 1'b0, '0, '0, 1, 1'b0, 1'b0));
    q1.push_back(mk(32'h0000_0900, 1'b0, '0, '0, 1, 1'b0, 1'b0));
    wait_idle("t6");
    check("t6_count", 32'(order_log.size() - base), 32'd2);
    check("t6_tie_first", 32'(order_log[base]), 32'd0);
    check("t6_tie_second", 32'(order_log[base + 1]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : guard
    #200000;
    $display("FAIL global_time_limit got=expired exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
